// File: rtl/h80_clkctl_if.sv
// h80_clkctl front-panel bundle: raw buttons in,
// conditioned CPU clock/reset and status out.
interface h80_clkctl_if;
  logic        btn_clk;
  logic        btn_reset;
  logic        cpu_clk;
  logic        cpu_reset;
  logic        autorun;
  logic [7:0]  status;
  logic [15:0] step_count;

  modport master (
    output btn_clk,
    output btn_reset,
    input  cpu_clk,
    input  cpu_reset,
    input  autorun,
    input  status,
    input  step_count
  );

  modport slave (
    input  btn_clk,
    input  btn_reset,
    output cpu_clk,
    output cpu_reset,
    output autorun,
    output status,
    output step_count
  );
endinterface

// File: rtl/h80_clkctl.sv
// h80 clock/reset conditioner: debounced run/step clock and stretched reset.
// Optional step counter built when H80_CLKCTL_STEPCNT_EN is defined.
module h80_clkctl #(
  parameter int TICK_DIV        = 65536,
  parameter int DEBOUNCE_TICKS  = 3,
  parameter int LONGPRESS_TICKS = 82,
  parameter int RUN_DIV_LOG2    = 1,
  parameter int RESET_STRETCH   = 8
) (
  input logic         sysclk,
  input logic         reset_n,
  h80_clkctl_if.slave bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (RUN_DIV_LOG2 > 0) ? RUN_DIV_LOG2 : 1;
  localparam int SW = (RESET_STRETCH > 0) ?
                      $clog2(RESET_STRETCH + 1) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PH_MAX   = PW'((1 << RUN_DIV_LOG2) - 1);
  localparam logic [15:0]   DB       = 16'(DEBOUNCE_TICKS);
  localparam logic [15:0]   LP       = 16'(LONGPRESS_TICKS);
  localparam logic [SW-1:0] RS       = SW'(RESET_STRETCH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [1:0]    bclk_s_q, brst_s_q;
  logic [TW-1:0] presc_q, presc_d;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          autorun_q, autorun_d;
  logic          pend_q, pend_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          cpu_clk_q, cpu_clk_d;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          cpu_rst_q, cpu_rst_d;

  logic        btn, brst, tick, wrap;
  logic        step_req, pend_clr;
  logic        run_rise, step_rise;
  logic [15:0] cnt_dec, cnt_inc;

  assign btn     = bclk_s_q[1];
  assign brst    = brst_s_q[1];
  assign tick    = (presc_q == TICK_MAX);
  assign wrap    = (phase_q == PH_MAX);
  assign cnt_dec = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;
  assign cnt_inc = cnt_q + 16'd1;
  assign presc_d = tick ? '0 : presc_q + TW'(1);
  assign phase_d = wrap ? '0 : phase_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    autorun_d = autorun_q;
    step_req  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (btn) begin
            cnt_d = cnt_dec;
            if (cnt_dec == 16'd0) state_d = PRESSED;
          end else begin
            cnt_d = DB;
          end
        end
        PRESSED: begin
          if (btn) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LP) begin
              autorun_d = ~autorun_q;
              state_d   = RELEASE;
              cnt_d     = DB;
            end
          end else begin
            step_req = ~autorun_q;
            state_d  = RELEASE;
            cnt_d    = DB;
          end
        end
        RELEASE: begin
          if (!btn) begin
            cnt_d = cnt_dec;
            if (cnt_dec == 16'd0) begin
              state_d = IDLE;
              cnt_d   = DB;
            end
          end else begin
            cnt_d = DB;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = DB;
        end
      endcase
    end
  end

  // Edges only at phase wraps, so neither phase can be a runt.
  assign run_rise  = ~cpu_clk_q & autorun_q;
  assign step_rise = ~cpu_clk_q & ~autorun_q & pend_q;

  always_comb begin
    cpu_clk_d = cpu_clk_q;
    pend_clr  = 1'b0;
    if (wrap) begin
      unique case (1'b1)
        cpu_clk_q: cpu_clk_d = 1'b0;
        run_rise:  cpu_clk_d = 1'b1;
        step_rise: begin
          cpu_clk_d = 1'b1;
          pend_clr  = 1'b1;
        end
        default:   cpu_clk_d = cpu_clk_q;
      endcase
    end
    pend_d = step_req | (pend_q & ~pend_clr);
  end

  always_comb begin
    stretch_d = stretch_q;
    cpu_rst_d = 1'b0;
    if (brst) begin
      stretch_d = RS;
      cpu_rst_d = 1'b1;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - SW'(1);
      cpu_rst_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s_q  <= 2'b00;
      brst_s_q  <= 2'b00;
      presc_q   <= '0;
      state_q   <= IDLE;
      cnt_q     <= DB;
      autorun_q <= 1'b1;
      pend_q    <= 1'b0;
      phase_q   <= '0;
      cpu_clk_q <= 1'b0;
      stretch_q <= RS;
      cpu_rst_q <= 1'b1;
    end else begin
      bclk_s_q  <= {bclk_s_q[0], bus.btn_clk};
      brst_s_q  <= {brst_s_q[0], bus.btn_reset};
      presc_q   <= presc_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      autorun_q <= autorun_d;
      pend_q    <= pend_d;
      phase_q   <= phase_d;
      cpu_clk_q <= cpu_clk_d;
      stretch_q <= stretch_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

`ifdef H80_CLKCTL_STEPCNT_EN
  logic [15:0] stepcnt_q, stepcnt_d;

  always_comb begin
    stepcnt_d = stepcnt_q;
    if (cpu_rst_q)
      stepcnt_d = 16'h0000;
    else if (wrap && step_rise)
      stepcnt_d = stepcnt_q + 16'd1;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) stepcnt_q <= 16'h0000;
    else          stepcnt_q <= stepcnt_d;
  end

  assign bus.step_count = stepcnt_q;
`else
  assign bus.step_count = 16'h0000;
`endif

  assign bus.cpu_clk   = cpu_clk_q;
  assign bus.cpu_reset = cpu_rst_q;
  assign bus.autorun   = autorun_q;
  assign bus.status    = {cpu_clk_q, autorun_q, state_q,
                          3'b000, pend_q};
endmodule
